// File: rtl/inst_fifo_pkg.sv
// Shared fetch/decode definitions: the instruction-queue entry format, the
// default queue depth and the push/pop counting helpers used by inst_fifo.
package inst_fifo_pkg;

  localparam int IFIFO_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pred;
    logic        excp;
  } entry_t;

  // Entries accepted this cycle; the whole write is dropped while full.
  function automatic logic [1:0] push_count(input logic en1, input logic en2,
                                            input logic is_full);
    logic [1:0] n;
    if (is_full) begin
      n = 2'd0;
    end else if (en1 && en2) begin
      n = 2'd2;
    end else if (en1 || en2) begin
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

  // Entries retired this cycle; slave pop only counts alongside the master.
  function automatic logic [1:0] pop_count(input logic re1, input logic re2,
                                           input logic has1, input logic has2);
    logic [1:0] n;
    if (!re1 || !has1) begin
      n = 2'd0;
    end else if (re2 && has2) begin
      n = 2'd2;
    end else begin
      n = 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode: two pushes and two
// show-ahead pops per cycle, with flush for redirects.
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = IFIFO_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_addr2,
  input  logic        write_pred1,
  input  logic        write_pred2,
  input  logic        write_excp1,
  input  logic        write_excp2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_addr1,
  output logic [31:0] read_addr2,
  output logic        read_pred1,
  output logic        read_pred2,
  output logic        read_excp1,
  output logic        read_excp2,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            empty_q, empty_d;
  logic            aempty_q, aempty_d;
  logic            full_q, full_d;

  logic [1:0]      push_cnt_s;
  logic [1:0]      pop_cnt_s;
  logic [AW-1:0]   head_p1_s;
  logic [AW-1:0]   tail_p1_s;
  logic            wr_a_en_s;
  logic            wr_b_en_s;
  entry_t          wr_a_s;
  entry_t          wr_b_s;
  entry_t          slot1_s;
  entry_t          slot2_s;

  // Neighbour pointers and the per-cycle push/pop amounts.
  always_comb begin
    head_p1_s  = head_q + AW'(1);
    tail_p1_s  = tail_q + AW'(1);
    push_cnt_s = push_count(write_en1, write_en2, full_q);
    pop_cnt_s  = pop_count(read_en1, read_en2,
                           count_q != (AW+1)'(0),
                           count_q >= (AW+1)'(2));
  end

  // Next pointers, occupancy and status flags; flush wins over all traffic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_cnt_s);
      tail_d  = tail_q + AW'(push_cnt_s);
      count_d = count_q + (AW+1)'(push_cnt_s) - (AW+1)'(pop_cnt_s);
    end
    empty_d  = (count_d == (AW+1)'(0));
    aempty_d = (count_d == (AW+1)'(1));
    full_d   = (count_d > (AW+1)'(DEPTH - 2));
  end

  // Status flags are kept as flops so they equal a decode of the count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      full_q   <= full_d;
    end
  end

  // A lone slot-2 write lands at the tail, keeping the queue dense.
  always_comb begin
    slot1_s   = '{inst: write_inst1, addr: write_addr1,
                  pred: write_pred1, excp: write_excp1};
    slot2_s   = '{inst: write_inst2, addr: write_addr2,
                  pred: write_pred2, excp: write_excp2};
    wr_a_en_s = resetn && !flush && !full_q && (write_en1 || write_en2);
    wr_b_en_s = resetn && !flush && !full_q && write_en1 && write_en2;
    if (write_en1) begin
      wr_a_s = slot1_s;
    end else begin
      wr_a_s = slot2_s;
    end
    wr_b_s = slot2_s;
  end

  // Storage array, deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_a_en_s) begin
      mem_q[tail_q] <= wr_a_s;
    end
    if (wr_b_en_s) begin
      mem_q[tail_p1_s] <= wr_b_s;
    end
  end

  // Show-ahead read ports: head and head+1 with no read latency.
  assign read_inst1   = mem_q[head_q].inst;
  assign read_addr1   = mem_q[head_q].addr;
  assign read_pred1   = mem_q[head_q].pred;
  assign read_excp1   = mem_q[head_q].excp;
  assign read_inst2   = mem_q[head_p1_s].inst;
  assign read_addr2   = mem_q[head_p1_s].addr;
  assign read_pred2   = mem_q[head_p1_s].pred;
  assign read_excp2   = mem_q[head_p1_s].excp;

  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign full         = full_q;

endmodule

// File: tb/tb_inst_fifo.sv
// Randomised and directed bench for inst_fifo against a queue-based model.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_inst2, write_addr1, write_addr2;
  logic        write_pred1, write_pred2, write_excp1, write_excp2;
  logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
  logic        read_pred1, read_pred2, read_excp1, read_excp2;
  logic        empty, almost_empty, full;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pred;
    logic        excp;
  } ent_t;

  ent_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] next_addr = 32'h0;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_pred1(write_pred1), .write_pred2(write_pred2),
    .write_excp1(write_excp1), .write_excp2(write_excp2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_inst1(read_inst1), .read_inst2(read_inst2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_pred1(read_pred1), .read_pred2(read_pred2),
    .read_excp1(read_excp1), .read_excp2(read_excp2),
    .empty(empty), .almost_empty(almost_empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: pops come from the front of the old contents, accepted pushes go to the back.
  task automatic model_step();
    int  n;
    int  pops;
    bit  is_full;
    ent_t e1, e2;
    n       = q.size();
    is_full = (n > DEPTH - 2);
    if (flush) begin
      q.delete();
    end else begin
      pops = 0;
      if (read_en1 && n >= 1) pops = (read_en2 && n >= 2) ? 2 : 1;
      repeat (pops) void'(q.pop_front());
      e1 = '{inst: write_inst1, addr: write_addr1, pred: write_pred1, excp: write_excp1};
      e2 = '{inst: write_inst2, addr: write_addr2, pred: write_pred2, excp: write_excp2};
      if (!is_full) begin
        if (write_en1) begin q.push_back(e1); next_addr += 32'd4; end
        if (write_en2) begin q.push_back(e2); next_addr += 32'd4; end
      end
    end
  endtask

  task automatic step(input bit we1, input bit we2, input bit re1, input bit re2, input bit fl);
    @(negedge clk);
    write_en1   = we1;
    write_en2   = we2;
    read_en1    = re1;
    read_en2    = re2;
    flush       = fl;
    write_inst1 = $urandom;
    write_inst2 = $urandom;
    write_pred1 = 1'($urandom_range(0, 1));
    write_pred2 = 1'($urandom_range(0, 1));
    write_excp1 = 1'($urandom_range(0, 1));
    write_excp2 = 1'($urandom_range(0, 1));
    write_addr1 = next_addr;
    write_addr2 = we1 ? next_addr + 32'd4 : next_addr;
    @(posedge clk);
    model_step();
    #1;
    write_en1 = 1'b0; write_en2 = 1'b0;
    read_en1  = 1'b0; read_en2  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Compare process: flags every cycle, data only for valid slots.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_empty", 32'(almost_empty), 32'(n == 1));
      chk("full", 32'(full), 32'(n > DEPTH - 2));
      if (n >= 1) begin
        chk("inst1", read_inst1, q[0].inst);
        chk("addr1", read_addr1, q[0].addr);
        chk("flags1", 32'({read_pred1, read_excp1}), 32'({q[0].pred, q[0].excp}));
      end
      if (n >= 2) begin
        chk("inst2", read_inst2, q[1].inst);
        chk("addr2", read_addr2, q[1].addr);
        chk("flags2", 32'({read_pred2, read_excp2}), 32'({q[1].pred, q[1].excp}));
      end
    end
  end

  initial begin
    int bias;
    resetn = 1'b0; flush = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
    write_inst1 = '0; write_inst2 = '0; write_addr1 = '0; write_addr2 = '0;
    write_pred1 = 1'b0; write_pred2 = 1'b0; write_excp1 = 1'b0; write_excp2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    settle();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    next_addr = 32'hBFC00000;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("push1_aempty", 32'(almost_empty), 32'd1);
    chk("push1_addr", read_addr1, 32'hBFC00000);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("pop_cnt1_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("full_ignored", 32'(full), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("after_pop_not_full", 32'(full), 32'd0);
    chk("after_pop_head", read_addr1, 32'hBFC00008);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("flush_empty", 32'(empty), 32'd1);

    next_addr = 32'h00001000;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("pushpop_head", read_addr1, 32'h00001008);
    chk("pushpop_head1", read_addr2, 32'h0000100C);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("pushpop_last_aempty", 32'(almost_empty), 32'd1);
    chk("pushpop_last_addr", read_addr1, 32'h00001018);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    next_addr = 32'h00400000;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("wrap_not_full", 32'(full), 32'd0);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      settle();
      chk("wrap_empty", 32'(empty), 32'd1);
    end
    chk("wrap_addr_seq", next_addr, 32'h00400070);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("flush_mix_empty", 32'(empty), 32'd1);
    chk("flush_mix_aempty", 32'(almost_empty), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("flush_mix_still_empty", 32'(empty), 32'd1);

    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(20, 80);
      if (i == 1500) begin
        @(negedge clk);
        #2 resetn = 1'b0;
        q.delete();
        #2 resetn = 1'b1;
      end
      step(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) < bias),
           1'($urandom_range(0, 99) >= bias), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port flush  in  1  discard all entries (exception or mispredict redirect).
REQ-005 SHALL have ports write_en1, write_en2  in  1 each  push fetch slot 1 / slot 2.
REQ-006 SHALL have ports write_inst1, write_inst2, write_addr1, write_addr2  in  32 each  instruction word and PC per slot.
REQ-007 SHALL have ports write_pred1, write_pred2, write_excp1, write_excp2  in  1 each  predicted-taken flag and fetch-exception flag per slot.
REQ-008 SHALL have ports read_en1, read_en2  in  1 each  decode pops master / slave slot.
REQ-009 SHALL have ports read_inst1, read_inst2, read_addr1, read_addr2  out  32 each  head and head+1 contents.
REQ-010 SHALL have ports read_pred1, read_pred2, read_excp1, read_excp2  out  1 each  head and head+1 flags.
REQ-011 SHALL have ports empty, almost_empty, full  out  1 each  occupancy status to the hazard unit.

Function
REQ-012 SHALL keep head pointer, tail pointer (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits).
REQ-013 SHALL present head entry on read_*1 and head+1 (mod DEPTH) on read_*2 combinationally; show-ahead, zero read latency.
REQ-014 SHALL drive empty = (count == 0), almost_empty = (count == 1), full = (count > DEPTH-2), all decoded from registered count only.
REQ-015 SHALL write slot 1 at tail and slot 2 at tail+1 when both enabled; write_en2 without write_en1 writes slot 2 at tail.
REQ-016 SHALL ignore all writes in any cycle where full is 1; upstream must stall (stallF) on full.
REQ-017 SHALL pop 1 entry on read_en1 with count >= 1, and 2 entries on read_en1 & read_en2 with count >= 2.
REQ-018 SHALL treat read_en2 without read_en1 as no pop; SHALL treat read_en1 & read_en2 with count == 1 as a single pop; SHALL ignore reads with count == 0.
REQ-019 SHALL allow a simultaneous push and pop in one cycle; count_next = count + pushes - pops.
REQ-020 SHALL NOT bypass: data written in cycle N becomes readable in cycle N+1.
REQ-021 SHALL, on flush, set head = tail = 0 and count = 0 at the next edge; flush overrides same-cycle reads and writes, which are discarded.
REQ-022 SHALL treat outputs at non-valid slots (count < 2 for slot 2, empty for slot 1) as don't-care; validity is conveyed only by empty and almost_empty.

Reset
REQ-023 SHALL asynchronously clear head, tail and count on resetn low, giving empty = 1, almost_empty = 0, full = 0.
REQ-024 SHALL NOT reset storage array contents; all read_* data outputs are don't-care until first write.
REQ-025 SHALL discard any in-flight push or pop when reset is asserted mid-cycle.

Structure
REQ-026 SHALL take the entry typedef (inst 32, addr 32, pred 1, excp 1) and the default DEPTH constant from the shared CPU package.
REQ-027 SHALL keep storage inline as a register array; no sub-module is required.

Verification
REQ-028 Bench SHALL cover: reset release -> empty = 1, almost_empty = 0, full = 0; single push (addr 0xBFC00000) -> next cycle almost_empty = 1, read_addr1 = 0xBFC00000.
REQ-029 Bench SHALL cover: dual pushes until count = 15 (DEPTH 16) -> full = 1; further dual push -> ignored, count stays 15.
REQ-030 Bench SHALL cover: count = 1 with read_en1 & read_en2 -> one pop, empty = 1 next cycle.
REQ-031 Bench SHALL cover: count = 5 with dual push and dual pop in the same cycle -> count = 5, head advanced by 2, order preserved.
REQ-032 Bench SHALL cover: 14 pushes then 14 pops repeated twice -> pointer wrap-around with FIFO order intact (addr sequence +4 each).
REQ-033 Bench SHALL cover: count = 6 with flush asserted alongside dual push and read_en1 -> next cycle count = 0, empty = 1, pushed data not visible.
